// File: rtl/sipo_frame_loader_if.sv
// sipo_frame_loader_if: serial strobe/start/ack inputs and held word/status outputs of the frame loader
interface sipo_frame_loader_if #(parameter int N = 8, parameter int CNT_W = 3);
  logic serial_in;
  logic serial_en;
  logic start;
  logic data_ack;
  logic [N-1:0] data_out;
  logic word_pending;
  logic busy;
  logic [CNT_W-1:0] bit_count;
  logic frame_err;
  logic overrun;
  modport master(
    output serial_in, serial_en, start, data_ack,
    input data_out, word_pending, busy, bit_count, frame_err, overrun
  );
  modport slave(
    input serial_in, serial_en, start, data_ack,
    output data_out, word_pending, busy, bit_count, frame_err, overrun
  );
endinterface

// File: rtl/sipo_frame_loader.sv
// sipo_frame_loader: assembles N serial bits into a held, ack-qualified word for a downstream PIPO bank
module sipo_frame_loader #(
  parameter int N = 8,
  parameter int CNT_W = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic CLK_BAR,
  input logic CLR,
  sipo_frame_loader_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [N-1:0] sr, sr_n, dout, dout_n, shifted;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic pend, pend_n, ferr, ferr_n, ovr, ovr_n;
  assign shifted = MSB_FIRST ? {sr[N-2:0], bus.serial_in} : {bus.serial_in, sr[N-1:1]};
  always_ff @(negedge CLK_BAR) begin
    if (CLR) begin
      state <= IDLE;
      sr <= '0;
      dout <= '0;
      cnt <= '0;
      pend <= 1'b0;
      ferr <= 1'b0;
      ovr <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      dout <= dout_n;
      cnt <= cnt_n;
      pend <= pend_n;
      ferr <= ferr_n;
      ovr <= ovr_n;
    end
  end
  // completion wins over a same-edge ack, so pend_n is overridden to 1 there
  always_comb begin
    state_n = state;
    sr_n = sr;
    dout_n = dout;
    cnt_n = cnt;
    pend_n = pend & ~bus.data_ack;
    ferr_n = 1'b0;
    ovr_n = ovr;
    if (state == IDLE) begin
      if (bus.start) begin
        state_n = SHIFT;
        sr_n = '0;
        cnt_n = '0;
      end
    end else if (bus.start) begin
      sr_n = '0;
      cnt_n = '0;
      ferr_n = 1'b1;
    end else if (bus.serial_en) begin
      sr_n = shifted;
      cnt_n = cnt + 1'b1;
      if (cnt == CNT_W'(N - 1)) begin
        dout_n = shifted;
        cnt_n = '0;
        state_n = IDLE;
        pend_n = 1'b1;
        ovr_n = ovr | (pend & ~bus.data_ack);
      end
    end
  end
  assign bus.data_out = dout;
  assign bus.word_pending = pend;
  assign bus.busy = (state == SHIFT);
  assign bus.bit_count = cnt;
  assign bus.frame_err = ferr;
  assign bus.overrun = ovr;
endmodule

// File: tb/tb_sipo_frame_loader.sv
// tb_sipo_frame_loader: directed checks of an MSB-first and an LSB-first loader fed the same serial stream
module tb_sipo_frame_loader;
  logic clk_bar = 1'b1;
  logic clr = 1'b0;
  logic s_in = 1'b0, s_en = 1'b0, st = 1'b0, ack = 1'b0;
  int passed = 0, total = 0;
  always #5 clk_bar = ~clk_bar;
  sipo_frame_loader_if #(.N(8), .CNT_W(3)) bm ();
  sipo_frame_loader_if #(.N(8), .CNT_W(3)) bl ();
  assign bm.serial_in = s_in;
  assign bm.serial_en = s_en;
  assign bm.start = st;
  assign bm.data_ack = ack;
  assign bl.serial_in = s_in;
  assign bl.serial_en = s_en;
  assign bl.start = st;
  assign bl.data_ack = ack;
  sipo_frame_loader #(.N(8), .CNT_W(3), .MSB_FIRST(1'b1)) u_msb (.CLK_BAR(clk_bar), .CLR(clr), .bus(bm));
  sipo_frame_loader #(.N(8), .CNT_W(3), .MSB_FIRST(1'b0)) u_lsb (.CLK_BAR(clk_bar), .CLR(clr), .bus(bl));
  task automatic tick();
    @(negedge clk_bar);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  // seq[7] is the first bit on the wire; ack_last raises data_ack on the completing edge
  task automatic bits(input logic [7:0] seq, input bit ack_last);
    s_en = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      s_in = seq[i];
      ack = ack_last && (i == 0);
      tick();
    end
    s_en = 1'b0;
    ack = 1'b0;
  endtask
  task automatic frame(input logic [7:0] seq, input bit ack_last);
    st = 1'b1;
    tick();
    st = 1'b0;
    bits(seq, ack_last);
  endtask
  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask
  initial begin
    tick();
    clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_in = 1'($urandom);
      s_en = 1'($urandom);
      st = 1'($urandom);
      ack = 1'($urandom);
      tick();
    end
    clr = 1'b0;
    {s_in, s_en, st, ack} = '0;
    chk("rst_dout", bm.data_out, 8'h00);
    chk("rst_pend", bm.word_pending, 0);
    chk("rst_busy", bm.busy, 0);
    chk("rst_ovr", bm.overrun, 0);
    chk("rst_cnt", bm.bit_count, 0);
    chk("rst_dout_lsb", bl.data_out, 8'h00);
    frame(8'hA5, 1'b0);
    chk("a5_msb", bm.data_out, 8'hA5);
    chk("a5_lsb", bl.data_out, 8'hA5);
    chk("a5_pend", bm.word_pending, 1);
    chk("a5_busy", bm.busy, 0);
    chk("a5_cnt", bm.bit_count, 0);
    do_ack();
    chk("a5_ack", bm.word_pending, 0);
    frame(8'hC0, 1'b0);
    chk("c0_msb", bm.data_out, 8'hC0);
    chk("c0_lsb", bl.data_out, 8'h03);
    chk("c0_ovr", bm.overrun, 0);
    do_ack();
    st = 1'b1;
    tick();
    st = 1'b0;
    chk("gap_busy", bm.busy, 1);
    for (int i = 7; i >= 0; i--) begin
      s_en = 1'b1;
      s_in = 1'((8'h96 >> i) & 1);
      tick();
      chk("gap_cnt_en", bm.bit_count, (8 - i) % 8);
      s_en = 1'b0;
      s_in = ~s_in;
      tick();
      chk("gap_cnt_hold", bm.bit_count, (8 - i) % 8);
    end
    chk("gap_msb", bm.data_out, 8'h96);
    chk("gap_lsb", bl.data_out, 8'h69);
    do_ack();
    st = 1'b1;
    tick();
    st = 1'b0;
    s_en = 1'b1;
    s_in = 1'b1;
    repeat (3) tick();
    chk("ab_cnt3", bm.bit_count, 3);
    st = 1'b1;
    s_in = 1'b1;
    tick();
    st = 1'b0;
    s_en = 1'b0;
    chk("ab_ferr", bm.frame_err, 1);
    chk("ab_cnt0", bm.bit_count, 0);
    chk("ab_busy", bm.busy, 1);
    chk("ab_dout_held", bm.data_out, 8'h96);
    chk("ab_pend", bm.word_pending, 0);
    tick();
    chk("ab_ferr_drop", bm.frame_err, 0);
    bits(8'h3C, 1'b0);
    chk("ab_3c_msb", bm.data_out, 8'h3C);
    chk("ab_3c_lsb", bl.data_out, 8'h3C);
    chk("ab_3c_pend", bm.word_pending, 1);
    chk("ab_3c_ovr", bm.overrun, 0);
    frame(8'hC3, 1'b0);
    chk("ovr_set", bm.overrun, 1);
    chk("ovr_dout", bm.data_out, 8'hC3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovr", bm.overrun, 0);
    frame(8'h3C, 1'b0);
    chk("ack2_pend0", bm.word_pending, 1);
    frame(8'h81, 1'b1);
    chk("ack2_ovr", bm.overrun, 0);
    chk("ack2_pend", bm.word_pending, 1);
    chk("ack2_dout", bm.data_out, 8'h81);
    st = 1'b1;
    tick();
    st = 1'b0;
    s_en = 1'b1;
    s_in = 1'b1;
    repeat (5) tick();
    chk("mid_cnt5", bm.bit_count, 5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    s_en = 1'b0;
    chk("mid_dout", bm.data_out, 8'h00);
    chk("mid_cnt", bm.bit_count, 0);
    chk("mid_busy", bm.busy, 0);
    chk("mid_pend", bm.word_pending, 0);
    chk("mid_ovr", bm.overrun, 0);
    chk("mid_ferr", bm.frame_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sipo_frame_loader.md
Name: sipo_frame_loader

Overview:
- Serial-to-parallel front end that sits directly upstream of the N-bit PIPO register bank.
- Assembles N serial bits into a word under a start/enable protocol and presents the word on a held parallel bus.
- Qualifies the word with a pending flag and ack handshake so the downstream PIPO captures a stable value.
- Flags aborted frames and overruns.

Parameters:
N, 8, word width; must match the downstream PIPO width; N >= 2
CNT_W, 3, bit-counter width; 2^CNT_W >= N
MSB_FIRST, 1, 1 = first serial bit lands in bit N-1; 0 = first serial bit lands in bit 0

Ports:
CLK_BAR  input  1  clock; all state updates on the falling edge of CLK_BAR, matching the D_FF family
CLR  input  1  synchronous active-high reset
serial_in  input  1  serial data bit, sampled when serial_en=1 in SHIFT
serial_en  input  1  bit strobe; one bit consumed per active edge with serial_en=1
start  input  1  frame start; begins a new frame
data_ack  input  1  downstream has consumed data_out; clears word_pending
data_out  output  N  last completed word, held until the next completion
word_pending  output  1  completed word not yet acknowledged
busy  output  1  high while state = SHIFT
bit_count  output  CNT_W  bits captured in the current frame
frame_err  output  1  one-cycle pulse when a frame is aborted by start
overrun  output  1  sticky; a word completed while the previous word was unacknowledged

Behaviour:
- "Edge" below means an active (falling) edge of CLK_BAR.
- Reset: if CLR=1 at an edge, all of the following take effect; CLR has priority over every other input.
  - state=IDLE
  - shift register=0, data_out=0, bit_count=0
  - word_pending=0, busy=0, frame_err=0, overrun=0
- States: IDLE, SHIFT.
- IDLE:
  - serial_en is ignored.
  - start=1 -> SHIFT; bit_count=0; shift register=0.
- SHIFT, serial_en=1, start=0:
  - MSB_FIRST=1: sr <= {sr[N-2:0], serial_in}.
  - MSB_FIRST=0: sr <= {serial_in, sr[N-1:1]}.
  - bit_count increments.
- Completion, when the captured bit is the Nth (bit_count = N-1 before the edge):
  - data_out is loaded with the full word including this bit, on the same edge.
  - bit_count returns to 0; state -> IDLE.
  - word_pending is set.
- SHIFT, serial_en=0, start=0: hold all state.
- SHIFT, start=1 (with or without serial_en):
  - Frame aborts and restarts: sr=0, bit_count=0, stay in SHIFT.
  - frame_err=1 for exactly one cycle; the bit on serial_in is discarded.
  - data_out, word_pending and overrun are unaffected.
- Handshake:
  - data_ack=1 with no completion on the same edge -> word_pending=0.
  - Completion with word_pending=1 and data_ack=0 -> overrun=1 (sticky until CLR); data_out is overwritten with the new word.
  - Completion with data_ack=1 on the same edge -> word_pending stays 1; no overrun.
  - data_ack with word_pending=0 has no effect.
- Outputs:
  - busy = (state == SHIFT).
  - All outputs are registered; no combinational path from inputs to outputs.
- Latency: data_out/word_pending valid immediately after the edge capturing the Nth bit. Minimum frame is 1 start edge plus N strobe edges.
- Back-to-back frames: start=1 at an edge in IDLE directly after a completion edge begins a new frame with no dead cycle.
- CLR mid-frame discards the partial word; data_out returns to 0.

Test Plan:
- Reset: CLR=1 for 2 edges with random inputs -> data_out=0x00, word_pending=0, busy=0, overrun=0, bit_count=0.
- MSB_FIRST=1, N=8: start, then bits 1,0,1,0,0,1,0,1 with serial_en=1 -> data_out=0xA5 after the 8th edge, word_pending=1, busy=0; data_ack -> word_pending=0.
- MSB_FIRST=0, same bit stream -> data_out=0xA5 (bit0 first: 1,0,1,0,0,1,0,1 -> 0xA5). Then stream 1,1,0,0,0,0,0,0 -> data_out=0x03.
- Gapped strobes: serial_en toggling 1/0 during the frame -> bit_count advances only on enabled edges; final word matches the stimulus.
- Abort: start, 3 bits, start again -> frame_err pulses 1 cycle, bit_count=0; the next 8 bits produce the correct word; the prior data_out is unchanged until completion.
- Overrun and CLR:
  - Complete word 0x3C, no ack, complete word 0xC3 -> overrun=1, data_out=0xC3.
  - Repeat with data_ack on the completion edge -> overrun stays 0, word_pending=1.
  - CLR asserted after 5 bits -> everything 0.
